// File: rtl/ysyx_22050550_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, execute redirect and
// the decode-facing output handshake. The IFU takes the master side.
interface ysyx_22050550_ifu_if #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32
) ();
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [PC_W-1:0]   mem_req_addr;
  logic              mem_rsp_valid;
  logic [INST_W-1:0] mem_rsp_data;
  logic              mem_rsp_err;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              valid_o;
  logic              ready_i;
  logic [PC_W-1:0]   pc_o;
  logic [INST_W-1:0] instr_o;
  logic              fault_o;

  modport master (
    output mem_req_valid, mem_req_addr, valid_o, pc_o, instr_o, fault_o,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  redirect_valid, redirect_pc, ready_i
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, valid_o, pc_o, instr_o, fault_o,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output redirect_valid, redirect_pc, ready_i
  );
endinterface

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: holds the fetch PC, issues one memory read at a time
// and presents each fetched word to decode through a one-entry output register.
// A redirect replaces the fetch PC and discards any fetch already in flight.
module ysyx_22050550_ifu #(
  parameter int unsigned      PC_W       = 64,
  parameter int unsigned      INST_W     = 32,
  parameter logic [PC_W-1:0]  RESET_PC   = PC_W'(64'h8000_0000),
  parameter logic [INST_W-1:0] FAULT_INST = INST_W'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst_n,
  ysyx_22050550_ifu_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic [INST_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;

  logic              req_fire;
  logic              out_fire;
  logic [PC_W-1:0]   redir_pc;

  assign req_fire = (state_q == StReq) && bus.mem_req_ready;
  assign out_fire = (state_q == StHold) && bus.ready_i;
  // Redirect targets are forced word-aligned.
  assign redir_pc = bus.redirect_pc & ~PC_W'(3);

  // Next-state, fetch PC and output-register update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    fault_d  = fault_q;

    if (bus.redirect_valid) begin
      pc_d = redir_pc;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (req_fire) begin
          state_d = StWait;
          // A redirect racing the handshake makes the accepted read stale.
          drop_d  = bus.redirect_valid;
        end
      end
      StWait: begin
        if (bus.mem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || bus.redirect_valid) begin
            state_d = StReq;
          end else begin
            state_d  = StHold;
            pc_out_d = pc_q;
            pc_d     = pc_q + PC_W'(4);
            instr_d  = bus.mem_rsp_err ? FAULT_INST : bus.mem_rsp_data;
            fault_d  = bus.mem_rsp_err;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        // A handshake in the redirect cycle still delivers the held word.
        if (out_fire || bus.redirect_valid) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      pc_out_q <= '0;
      instr_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.mem_req_valid = (state_q == StReq);
  assign bus.mem_req_addr  = pc_q;
  assign bus.valid_o       = (state_q == StHold);
  assign bus.pc_o          = pc_out_q;
  assign bus.instr_o       = instr_q;
  assign bus.fault_o       = fault_q;

endmodule

// File: doc/ysyx_22050550_ifu.md
Name: ysyx_22050550_ifu

Overview:
- Instruction fetch unit. It is the producer of the pc/instruction stream that the decode stage consumes.
- Holds the architectural fetch PC and issues single-outstanding instruction reads to instruction memory over a valid/ready request and valid response interface.
- Presents each fetched instruction to decode through a one-entry output register with valid/ready handshake.
- Accepts a redirect (taken jump/branch from execute) that flushes the in-flight fetch.

Parameters:
- PC_W, 64, width of PC and memory address.
- INST_W, 32, instruction width.
- RESET_PC, 64'h8000_0000, PC value loaded at reset.
- FAULT_INST, 32'h0000_0013, instruction substituted on a fetch error (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  PC_W  fetch address.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  INST_W  fetched word.
- mem_rsp_err  in  1  access fault on this response.
- redirect_valid  in  1  one-cycle redirect pulse from execute.
- redirect_pc  in  PC_W  redirect target.
- valid_o  out  1  instruction available to decode.
- ready_i  in  1  decode accepts instruction.
- pc_o  out  PC_W  PC of presented instruction.
- instr_o  out  INST_W  presented instruction.
- fault_o  out  1  presented instruction came from an errored fetch.

Behaviour:
- Reset (async assert, any state): fetch pc=RESET_PC; state=IDLE; drop=0; valid_o=0; mem_req_valid=0; pc_o=0; instr_o=0; fault_o=0. On release, IDLE->REQ on the first clk edge.
- States: IDLE, REQ, WAIT, HOLD. Outputs are registered or decoded from state only. mem_req_valid=(state==REQ). mem_req_addr=fetch pc. valid_o=(state==HOLD).
- REQ: on mem_req_valid&mem_req_ready, go to WAIT.
- WAIT: on mem_rsp_valid, capture pc_o=fetch pc and fetch pc+=4. instr_o=mem_rsp_data, or FAULT_INST with fault_o=1 if mem_rsp_err. Go to HOLD.
- HOLD: on valid_o&ready_i, go to REQ.
- Minimum cost is 3 cycles per instruction with zero-wait memory. pc arithmetic is modulo 2^PC_W (wraps silently).
- mem_rsp_valid outside WAIT is ignored. This includes stale responses after reset.
- Memory samples the address only on handshake. A changed address while mem_req_valid is pending and not yet accepted is legal.
- Redirect: fetch pc<=redirect_pc with bits[1:0] forced to 0. Per state:
  - IDLE: pc updated; still go to REQ.
  - REQ without handshake: pc updated, stay in REQ.
  - REQ with handshake in the same cycle: go to WAIT with drop=1; that response is discarded.
  - WAIT: drop<=1; remain in WAIT.
  - WAIT with mem_rsp_valid in the same cycle: the response is discarded; go to REQ.
  - HOLD: valid_o cleared next cycle; go to REQ. A concurrent ready_i handshake still counts as delivered.
- WAIT with drop=1 on mem_rsp_valid: discard, clear drop, go to REQ. pc is not incremented, and pc_o/instr_o/fault_o are unchanged.
- pc_o/instr_o/fault_o are stable while valid_o=1 and ready_i=0.
- Never more than one outstanding memory request.

Test Plan:
- Reset release, memory always ready, 1-cycle response of 0x00100093 then 0x00200113, ready_i=1 -> first request addr 0x8000_0000. valid_o with pc_o=0x8000_0000 / instr_o=0x00100093, then pc_o=0x8000_0004 / instr_o=0x00200113, 3 cycles apart.
- ready_i=0 for 5 cycles in HOLD -> valid_o stays 1, outputs stable, mem_req_valid=0 throughout; request for 0x8000_0004 issues the cycle after ready_i rises.
- Redirect to 0x8000_0103 while in WAIT, old response arrives 2 cycles later -> old data never presented; next request addr 0x8000_0100; delivered pc_o=0x8000_0100.
- Redirect coincident with mem_rsp_valid in WAIT, and separately while in HOLD -> neither word is presented after the redirect; next fetch addr = redirect target.
- mem_rsp_err=1 at pc 0x8000_0008 -> valid_o with instr_o=0x00000013, fault_o=1; next fetch 0x8000_000C with fault_o=0.
- rst_n asserted mid-WAIT, response arrives during reset and after release -> outputs at reset values immediately; stale response ignored; fetch restarts at 0x8000_0000.
